// File: rtl/zuc_keystream_xor.sv
// Keystream consumer: buffers ZUC Z words in a small FIFO and XORs them with a
// plaintext word stream, masking the tail of the final partial word.
module zuc_keystream_xor #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [12:0] len_bits,
   output logic        gen_start,
   output logic [7:0]  L_req,
   input  logic        ks_valid,
   input  logic [31:0] ks_word,
   input  logic [7:0]  ks_idx,
   input  logic        pt_valid,
   output logic        pt_ready,
   input  logic [31:0] pt_data,
   output logic        ct_valid,
   input  logic        ct_ready,
   output logic [31:0] ct_data,
   output logic        ct_last,
   output logic        busy,
   output logic        err
);

   localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, REQ, RUN, DONE} state_t;
   state_t state_reg, state_next;

   logic [31:0]   fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]   fill_reg;
   logic [7:0]    nwords_reg, exp_idx_reg, ks_cnt_reg, words_out_reg;
   logic [4:0]    rem_reg;

   logic [13:0]   len_round;
   logic [7:0]    nwords_calc;
   logic          len_ok, full, empty, ks_take, push, pop, last_word;
   logic [31:0]   head, mask;

   // ceil(len/32); 8160 is the largest legal length, so bit 13 never sets
   assign len_round   = {1'b0, len_bits} + 14'd31;
   assign nwords_calc = len_round[12:5];
   assign len_ok      = (len_bits != 13'd0) && (len_bits <= 13'd8160);

   assign full      = (fill_reg == (AW+1)'(FIFO_DEPTH));
   assign empty     = (fill_reg == '0);
   assign head      = fifo_mem[rd_ptr_reg];
   assign ks_take   = (state_reg == RUN) && ks_valid && (ks_cnt_reg < nwords_reg);
   assign pop       = pt_valid && pt_ready;
   assign push      = ks_take && (!full || pop);
   assign last_word = (words_out_reg == nwords_reg - 8'd1);
   assign mask      = (last_word && rem_reg != 5'd0) ? ~(32'hFFFF_FFFF >> rem_reg) : 32'hFFFF_FFFF;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (start && len_ok) state_next = REQ;
         REQ:  state_next = RUN;
         RUN:  if (ct_valid && ct_ready && ct_last) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      gen_start = (state_reg == REQ);
      busy      = (state_reg != IDLE);
      pt_ready  = (state_reg == RUN) && !empty && (words_out_reg < nwords_reg)
                  && (!ct_valid || ct_ready);
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_reg] <= ks_word;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         fill_reg      <= '0;
         nwords_reg    <= '0;
         rem_reg       <= '0;
         exp_idx_reg   <= '0;
         ks_cnt_reg    <= '0;
         words_out_reg <= '0;
         L_req         <= '0;
         err           <= 1'b0;
         ct_valid      <= 1'b0;
         ct_data       <= '0;
         ct_last       <= 1'b0;
      end else begin
         if (state_reg == IDLE && start) begin
            if (len_ok) begin
               nwords_reg    <= nwords_calc;
               rem_reg       <= len_bits[4:0];
               L_req         <= nwords_calc;
               err           <= 1'b0;
               exp_idx_reg   <= '0;
               ks_cnt_reg    <= '0;
               words_out_reg <= '0;
               wr_ptr_reg    <= '0;
               rd_ptr_reg    <= '0;
               fill_reg      <= '0;
            end else begin
               err <= 1'b1;
            end
         end

         // A dropped word still advances the index so later words stay aligned
         if (ks_take) begin
            exp_idx_reg <= exp_idx_reg + 8'd1;
            ks_cnt_reg  <= ks_cnt_reg + 8'd1;
            if (ks_idx != exp_idx_reg || !push) err <= 1'b1;
         end

         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (push && !pop)      fill_reg <= fill_reg + 1'b1;
         else if (pop && !push) fill_reg <= fill_reg - 1'b1;

         if (pop) begin
            ct_data       <= (pt_data ^ head) & mask;
            ct_valid      <= 1'b1;
            ct_last       <= last_word;
            words_out_reg <= words_out_reg + 8'd1;
         end else if (ct_ready) begin
            ct_valid <= 1'b0;
            ct_last  <= 1'b0;
         end

         if (state_reg == DONE) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_zuc_keystream_xor.sv
// Directed bench for zuc_keystream_xor: hand-computed ciphertext vectors,
// backpressure, overflow, index mismatch, async reset and length bounds.
module tb_zuc_keystream_xor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [12:0] len_bits = '0;
   logic        gen_start;
   logic [7:0]  L_req;
   logic        ks_valid = 1'b0;
   logic [31:0] ks_word = '0;
   logic [7:0]  ks_idx = '0;
   logic        pt_valid = 1'b0;
   logic        pt_ready;
   logic [31:0] pt_data = '0;
   logic        ct_valid;
   logic        ct_ready = 1'b1;
   logic [31:0] ct_data;
   logic        ct_last;
   logic        busy;
   logic        err;

   int total = 0;
   int bad = 0;
   int gs_cnt = 0;
   int gs_before;

   zuc_keystream_xor #(.FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .len_bits(len_bits),
      .gen_start(gen_start), .L_req(L_req),
      .ks_valid(ks_valid), .ks_word(ks_word), .ks_idx(ks_idx),
      .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
      .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
      .ct_last(ct_last), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (gen_start) gs_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic do_start(input logic [12:0] len);
      @(negedge clk); start = 1'b1; len_bits = len;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_ks(input logic [31:0] w, input logic [7:0] idx);
      @(negedge clk); ks_valid = 1'b1; ks_word = w; ks_idx = idx;
      @(negedge clk); ks_valid = 1'b0;
   endtask

   task automatic send_pt(input string tag, input logic [31:0] d,
                          input logic [31:0] exp_ct, input logic exp_last);
      int n;
      n = 0;
      @(negedge clk); pt_data = d; pt_valid = 1'b1;
      while (!pt_ready && n < 50) begin @(negedge clk); n++; end
      chk({tag, "_ready"}, {31'b0, pt_ready}, 32'd1);
      @(negedge clk); pt_valid = 1'b0;
      chk({tag, "_valid"}, {31'b0, ct_valid}, 32'd1);
      chk({tag, "_data"}, ct_data, exp_ct);
      chk({tag, "_last"}, {31'b0, ct_last}, {31'b0, exp_last});
   endtask

   task automatic finish_msg(input string tag);
      @(negedge clk); chk({tag, "_busy_done"}, {31'b0, busy}, 32'd1);
      @(negedge clk); chk({tag, "_busy_idle"}, {31'b0, busy}, 32'd0);
   endtask

   task automatic pulse_rst();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
   endtask

   initial begin
      #12;
      chk("rst_ct_valid", {31'b0, ct_valid}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_err", {31'b0, err}, 32'd0);
      chk("rst_lreq", {24'b0, L_req}, 32'd0);
      chk("rst_gen_start", {31'b0, gen_start}, 32'd0);
      chk("rst_pt_ready", {31'b0, pt_ready}, 32'd0);
      @(negedge clk); rst = 1'b0;

      // plain two-word message
      gs_before = gs_cnt;
      do_start(13'd64);
      chk("t1_gen_start_cnt", gs_cnt - gs_before, 32'd1);
      chk("t1_lreq", {24'b0, L_req}, 32'd2);
      send_ks(32'h1111_1111, 8'd0);
      send_ks(32'h2222_2222, 8'd1);
      send_pt("t1_w0", 32'hAAAA_AAAA, 32'hBBBB_BBBB, 1'b0);
      send_pt("t1_w1", 32'h5555_5555, 32'h7777_7777, 1'b1);
      chk("t1_err", {31'b0, err}, 32'd0);
      finish_msg("t1");

      // partial final word, 40 bits
      do_start(13'd40);
      chk("t2_lreq", {24'b0, L_req}, 32'd2);
      send_ks(32'h0, 8'd0);
      send_ks(32'h0, 8'd1);
      send_pt("t2_w0", 32'h1234_5678, 32'h1234_5678, 1'b0);
      send_pt("t2_w1", 32'hFFFF_FFFF, 32'hFF00_0000, 1'b1);
      finish_msg("t2");

      // backpressure on the second of three words
      do_start(13'd96);
      send_ks(32'h0F0F_0F0F, 8'd0);
      send_ks(32'hF0F0_F0F0, 8'd1);
      send_ks(32'h1234_5678, 8'd2);
      send_pt("t3_w0", 32'h0101_0101, 32'h0E0E_0E0E, 1'b0);
      @(negedge clk); ct_ready = 1'b0; pt_valid = 1'b1; pt_data = 32'h1010_1010;
      @(negedge clk); pt_data = 32'hFFFF_FFFF;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t3_hold%0d_data", i), ct_data, 32'hE0E0_E0E0);
         chk($sformatf("t3_hold%0d_valid", i), {31'b0, ct_valid}, 32'd1);
         chk($sformatf("t3_hold%0d_ptready", i), {31'b0, pt_ready}, 32'd0);
         if (i < 4) @(negedge clk);
      end
      ct_ready = 1'b1;
      @(negedge clk); pt_valid = 1'b0;
      chk("t3_w2_data", ct_data, 32'hEDCB_A987);
      chk("t3_w2_last", {31'b0, ct_last}, 32'd1);
      finish_msg("t3");

      // overflow: five keystream words into a four-deep FIFO
      do_start(13'd160);
      for (int i = 0; i < 5; i++) begin
         send_ks(32'h0101_0101 * (i + 1), 8'(i));
         if (i == 3) chk("t4_err_before", {31'b0, err}, 32'd0);
      end
      chk("t4_err_after", {31'b0, err}, 32'd1);
      for (int i = 0; i < 4; i++)
         send_pt($sformatf("t4_w%0d", i), 32'hA5A5_A5A5 + i,
                 (32'hA5A5_A5A5 + i) ^ (32'h0101_0101 * (i + 1)), 1'b0);
      pulse_rst();

      // index mismatch: second word carries idx 2
      do_start(13'd64);
      send_ks(32'h1111_1111, 8'd0);
      chk("t5_err_first", {31'b0, err}, 32'd0);
      send_ks(32'h2222_2222, 8'd2);
      chk("t5_err_second", {31'b0, err}, 32'd1);
      send_pt("t5_w0", 32'h0, 32'h1111_1111, 1'b0);
      send_pt("t5_w1", 32'hFFFF_FFFF, 32'hDDDD_DDDD, 1'b1);
      finish_msg("t5");

      // asynchronous reset while a ciphertext word is pending
      do_start(13'd64);
      send_ks(32'h3333_3333, 8'd5);
      ct_ready = 1'b0;
      @(negedge clk); pt_valid = 1'b1; pt_data = 32'h0;
      @(negedge clk); pt_valid = 1'b0;
      chk("t6_pre_valid", {31'b0, ct_valid}, 32'd1);
      chk("t6_pre_err", {31'b0, err}, 32'd1);
      @(posedge clk); #3 rst = 1'b1;
      #1;
      chk("t6_async_ct_valid", {31'b0, ct_valid}, 32'd0);
      chk("t6_async_busy", {31'b0, busy}, 32'd0);
      chk("t6_async_err", {31'b0, err}, 32'd0);
      @(negedge clk); rst = 1'b0; ct_ready = 1'b1;
      do_start(13'd32);
      chk("t6_lreq", {24'b0, L_req}, 32'd1);
      send_ks(32'hDEAD_BEEF, 8'd0);
      send_pt("t6_w0", 32'h0, 32'hDEAD_BEEF, 1'b1);
      chk("t6_err", {31'b0, err}, 32'd0);
      finish_msg("t6");

      // length bounds
      gs_before = gs_cnt;
      do_start(13'd0);
      chk("t7_len0_err", {31'b0, err}, 32'd1);
      chk("t7_len0_busy", {31'b0, busy}, 32'd0);
      do_start(13'd8161);
      chk("t7_len8161_err", {31'b0, err}, 32'd1);
      chk("t7_len8161_busy", {31'b0, busy}, 32'd0);
      chk("t7_no_gen_start", gs_cnt - gs_before, 32'd0);
      do_start(13'd8160);
      chk("t7_len8160_lreq", {24'b0, L_req}, 32'd255);
      chk("t7_len8160_err", {31'b0, err}, 32'd0);
      chk("t7_len8160_busy", {31'b0, busy}, 32'd1);
      pulse_rst();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/zuc_keystream_xor.md
Name: zuc_keystream_xor

Overview:
Downstream consumer of the ZUC keystream generator. Requests an L-word keystream for one message, buffers incoming Z words in a small FIFO, and XORs them with plaintext words over a valid/ready stream to produce ciphertext (EEA3-style confidentiality). Masks the final partial word to the message bit length and flags keystream overflow or sequencing errors.

Parameters:
FIFO_DEPTH, 4, keystream word buffer depth (power of 2, at least 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle pulse: begin message; sampled only in IDLE
len_bits  input  13  message length in bits, legal range 1..8160; sampled with start
gen_start  output  1  one-cycle pulse to the generator to begin keystream production
L_req  output  8  keystream words requested, ceil(len_bits/32); held until next start
ks_valid  input  1  generator done strobe, one Z word per pulse
ks_word  input  32  generator Z word
ks_idx  input  8  generator L_out, 0-based word index
pt_valid  input  1  plaintext word valid
pt_ready  output  1  plaintext word accepted when pt_valid and pt_ready are both high
pt_data  input  32  plaintext word, MSB = first message bit
ct_valid  output  1  ciphertext word valid
ct_ready  input  1  downstream accepts ciphertext
ct_data  output  32  ciphertext word
ct_last  output  1  high with the final ciphertext word
busy  output  1  high in every state except IDLE
err  output  1  sticky error; cleared on start or rst

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; FIFO empty; gen_start, L_req, ct_valid, ct_data, ct_last, busy, and err all 0. pt_ready is 0 because it decodes from state.
- States: IDLE, REQ, RUN, DONE.
- IDLE -> REQ on start:
  - latch nwords = ceil(len_bits/32) and rem = len_bits[4:0];
  - L_req <= nwords; clear err, expected index (exp_idx <= 0), and word counters.
- REQ: gen_start=1 for exactly this cycle; then go to RUN.
- RUN, keystream side:
  - on ks_valid, push ks_word if the FIFO is not full, or if it is full but a pop occurs in the same cycle;
  - otherwise drop the word and set err;
  - if ks_idx != exp_idx, set err; the word is still pushed;
  - exp_idx increments on every ks_valid.
  - ks_valid in IDLE, or after nwords keystream words have been received, is ignored with no error.
- RUN, plaintext side:
  - pt_ready = (state==RUN) & FIFO not empty & (words_out < nwords) & (!ct_valid | ct_ready);
  - on a pt handshake, pop the FIFO head and register ct_data <= pt_data ^ head;
  - ct_valid <= 1 and words_out <= words_out + 1;
  - latency is 1 cycle from the pt handshake to ct_valid.
- Final word masking: on the word with words_out==nwords-1, if rem != 0, bits [31-rem:0] of ct_data are forced to 0 and bits [31:32-rem] are kept. ct_last=1 with that word.
- Output register: ct_valid clears on ct_ready unless a new word is loaded in the same cycle. ct_data, ct_valid, and ct_last hold stable while ct_valid & !ct_ready.
- RUN -> DONE when the last word handshakes on ct (ct_valid & ct_ready & ct_last). DONE lasts one cycle, flushes the FIFO, then returns to IDLE.
- start while busy: ignored.
- len_bits of 0 or above 8160 at start: set err, remain in IDLE, no gen_start.
- err does not stop processing; words that were dropped on overflow leave the stream stalled. Recovery is by rst or a new start.

Test Plan:
- Plain 2-word message: len_bits=64; ks 0x11111111 (idx 0) then 0x22222222 (idx 1); pt 0xAAAAAAAA then 0x55555555; ct_ready=1.
  Required: one gen_start pulse; L_req=2; ct_data 0xBBBBBBBB then 0x77777777; ct_last on the second word only; err=0; busy drops after DONE.
- Partial final word: len_bits=40; ks 0x00000000 twice; pt 0x12345678 then 0xFFFFFFFF.
  Required: ct 0x12345678 then 0xFF000000 with ct_last.
- Backpressure: ct_ready held low for 5 cycles during the 3-word message (len_bits=96).
  Required: ct_data stable; pt_ready=0 while ct_valid & !ct_ready; all 3 words correct afterwards.
- Overflow: FIFO_DEPTH=4; 5 ks pulses (idx 0..4) with pt_valid=0 and len_bits=160.
  Required: err=1 after the 5th pulse; the first 4 ct words equal pt XOR ks[0..3].
- Index mismatch: ks_idx sequence 0 then 2.
  Required: err=1 on the second pulse; the word is still used for ct.
- Reset mid-RUN: rst asserted asynchronously between clock edges.
  Required: ct_valid, busy, and err go to 0 immediately; after release, a new start with len_bits=32 completes normally.
